ct_apb_slv_dec: RTL

CT_APB_SLV_DEC -- requirements
Module: ct_apb_slv_dec

---
 rtl/ct_apb_slv_dec.sv | 89 ++++++++
 1 files changed

// File: rtl/ct_apb_slv_dec.sv
// ct_apb_slv_dec: APB bridge decoding a 16 KiB window into four 4 KiB slaves.
// Unmapped addresses and slaves that never respond both return an error.
module ct_apb_slv_dec #(
  parameter int                TOUT_W   = 8,
  parameter logic [TOUT_W-1:0] TOUT_MAX = 8'd255
) (
  input  logic         apb_clk,
  input  logic         apbrst_b,
  input  logic         m_psel,
  input  logic         m_penable,
  input  logic [31:0]  m_paddr,
  input  logic         m_pwrite,
  input  logic [31:0]  m_pwdata,
  output logic [31:0]  m_prdata,
  output logic         m_pready,
  output logic         m_pslverr,
  output logic [3:0]   s_psel,
  output logic         s_penable,
  output logic [31:0]  s_paddr,
  output logic         s_pwrite,
  output logic [31:0]  s_pwdata,
  input  logic [3:0]   s_pready,
  input  logic [3:0]   s_perr,
  input  logic [127:0] s_prdata
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t r_state, w_nxt;
  logic [1:0] r_slot;
  logic [TOUT_W-1:0] r_cnt, w_cnt_inc;
  logic [31:0] r_paddr, r_pwdata, r_rdata, w_srdata;
  logic r_pwrite, r_err, w_setup, w_mapped, w_rdy, w_serr, w_tout;
  assign w_setup   = m_psel & ~m_penable;
  assign w_mapped  = m_paddr[31:14] == 18'd0;
  assign w_rdy     = s_pready[r_slot];
  assign w_serr    = s_perr[r_slot];
  assign w_srdata  = s_prdata[{r_slot, 5'd0} +: 32];
  assign w_cnt_inc = (r_cnt == TOUT_MAX) ? r_cnt : r_cnt + 1'b1;
  // Timeout fires when this ACCESS cycle brings the count up to TOUT_MAX.
  assign w_tout    = w_cnt_inc == TOUT_MAX;
  always_ff @(posedge apb_clk or negedge apbrst_b)
    if (!apbrst_b) r_state <= IDLE;
    else r_state <= w_nxt;
  always_comb begin
    w_nxt = IDLE;
    case (r_state)
      IDLE:    w_nxt = w_setup ? (w_mapped ? SETUP : RESP) : IDLE;
      SETUP:   w_nxt = m_psel ? ACCESS : IDLE;
      ACCESS:  w_nxt = !m_psel ? IDLE : (w_rdy | w_tout) ? RESP : ACCESS;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge apb_clk or negedge apbrst_b)
    if (!apbrst_b) begin
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_slot   <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else if (r_state == IDLE && w_setup) begin
      r_paddr  <= m_paddr;
      r_pwdata <= m_pwdata;
      r_pwrite <= m_pwrite;
      r_slot   <= m_paddr[13:12];
      r_cnt    <= '0;
      r_err    <= ~w_mapped;
      r_rdata  <= '0;
    end else if (r_state == ACCESS) begin
      r_cnt <= w_cnt_inc;
      if (w_rdy) begin
        r_rdata <= r_pwrite ? 32'd0 : w_srdata;
        r_err   <= w_serr;
      end else if (w_tout) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  always_comb begin
    s_psel    = (r_state == SETUP || r_state == ACCESS) ? 4'b0001 << r_slot : 4'b0000;
    s_penable = r_state == ACCESS;
    s_paddr   = r_paddr;
    s_pwrite  = r_pwrite;
    s_pwdata  = r_pwdata;
    m_pready  = r_state == RESP;
    m_pslverr = m_pready & r_err;
    m_prdata  = m_pready ? r_rdata : 32'd0;
  end
endmodule
